// File: rtl/uart_b_host.sv
// Command-driven initiator for uart_b_dp: turns set-baud / send / receive commands
// into the control, baud and transfer register accesses the datapath expects.
module uart_b_host #(
  parameter int FRAME_BITS    = 10,
  parameter int TX_GUARD_BITS = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  input  logic [1:0]  cmd_op,
  input  logic [19:0] cmd_data,
  output logic        cmd_ready,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [7:0]  rsp_data,
  output logic        sel_tr,
  output logic        sel_ctrl,
  output logic        sel_baud,
  output logic        enable,
  output logic [31:0] data_out,
  input  logic [31:0] data_in,
  input  logic        tx_en
);

  typedef enum logic [2:0] {
    IDLE, WR_BAUD, CFG_CTRL, TX_LOAD, TX_WAIT, RX_HOLD, RESP
  } state_e;

  state_e      state_q;
  logic [1:0]  op_q;
  logic [7:0]  byte_q;
  logic [19:0] baud_q;
  logic [6:0]  ctrl_q;
  logic [23:0] cnt_q;
  logic        seen_busy_q;
  logic        cmd_ready_q, rsp_valid_q, rsp_err_q;
  logic [7:0]  rsp_data_q;
  logic        sel_tr_q, sel_ctrl_q, sel_baud_q, enable_q;
  logic [31:0] data_out_q;
  logic [23:0] tx_lim, rx_lim;
  logic        unused_ok;

  // Terminal counts; 24 bits holds 12 * (2^20-1) without overflow.
  assign tx_lim    = 24'(TX_GUARD_BITS) * {4'b0, baud_q} - 24'd1;
  assign rx_lim    = 24'(FRAME_BITS) * {4'b0, baud_q} - 24'd1;
  assign unused_ok = ^data_in[31:8];

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_data  = rsp_data_q;
  assign sel_tr    = sel_tr_q;
  assign sel_ctrl  = sel_ctrl_q;
  assign sel_baud  = sel_baud_q;
  assign enable    = enable_q;
  assign data_out  = data_out_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      op_q        <= 2'b00;
      byte_q      <= 8'h00;
      baud_q      <= 20'h0;
      ctrl_q      <= 7'h0;
      cnt_q       <= 24'h0;
      seen_busy_q <= 1'b0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= 8'h00;
      sel_tr_q    <= 1'b0;
      sel_ctrl_q  <= 1'b0;
      sel_baud_q  <= 1'b0;
      enable_q    <= 1'b0;
      data_out_q  <= 32'h0;
    end else begin
      // Strobes default low; each branch raises only what the next state drives.
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      sel_tr_q    <= 1'b0;
      sel_ctrl_q  <= 1'b0;
      sel_baud_q  <= 1'b0;
      enable_q    <= 1'b0;
      data_out_q  <= 32'h0;
      cnt_q       <= 24'h0;
      case (state_q)
        IDLE: begin
          cmd_ready_q <= 1'b1;
          if (cmd_valid) begin
            cmd_ready_q <= 1'b0;
            op_q        <= cmd_op;
            byte_q      <= cmd_data[7:0];
            if (cmd_op == 2'b11 || (cmd_op != 2'b00 && baud_q == 20'h0)) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_data_q  <= 8'h00;
            end else if (cmd_op == 2'b00) begin
              state_q    <= WR_BAUD;
              enable_q   <= 1'b1;
              sel_baud_q <= 1'b1;
              data_out_q <= {12'b0, cmd_data};
              baud_q     <= cmd_data;
            end else if (cmd_op == 2'b01) begin
              enable_q <= 1'b1;
              if (ctrl_q != 7'd1) begin
                state_q    <= CFG_CTRL;
                sel_ctrl_q <= 1'b1;
                data_out_q <= 32'd1;
                ctrl_q     <= 7'd1;
              end else begin
                state_q    <= TX_LOAD;
                sel_tr_q   <= 1'b1;
                data_out_q <= {24'b0, cmd_data[7:0]};
              end
            end else begin
              enable_q <= 1'b1;
              if (ctrl_q != 7'd2) begin
                state_q    <= CFG_CTRL;
                sel_ctrl_q <= 1'b1;
                data_out_q <= 32'd2;
                ctrl_q     <= 7'd2;
              end else begin
                state_q  <= RX_HOLD;
                sel_tr_q <= 1'b1;
              end
            end
          end
        end
        WR_BAUD: begin
          state_q     <= RESP;
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= 1'b0;
          rsp_data_q  <= 8'h00;
        end
        CFG_CTRL: begin
          enable_q <= 1'b1;
          sel_tr_q <= 1'b1;
          if (op_q == 2'b01) begin
            state_q    <= TX_LOAD;
            data_out_q <= {24'b0, byte_q};
          end else begin
            state_q <= RX_HOLD;
          end
        end
        TX_LOAD: begin
          state_q     <= TX_WAIT;
          seen_busy_q <= 1'b0;
        end
        TX_WAIT: begin
          if (tx_en) seen_busy_q <= 1'b1;
          if (seen_busy_q && !tx_en) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= 8'h00;
          end else if (cnt_q == tx_lim) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_data_q  <= 8'h00;
          end else begin
            cnt_q <= cnt_q + 24'd1;
          end
        end
        RX_HOLD: begin
          if (cnt_q == rx_lim) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= data_in[7:0];
          end else begin
            enable_q <= 1'b1;
            sel_tr_q <= 1'b1;
            cnt_q    <= cnt_q + 24'd1;
          end
        end
        RESP: begin
          state_q     <= IDLE;
          cmd_ready_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_b_host.sv
// Directed bench for uart_b_host: stimulus pushes expected responses (cycle, err, data),
// a negedge monitor pops and compares whenever rsp_valid is seen.
module tb_uart_b_host;

  logic        clk = 1'b0, rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_op = 2'b00;
  logic [19:0] cmd_data = 20'h0;
  logic        cmd_ready, rsp_valid, rsp_err;
  logic [7:0]  rsp_data;
  logic        sel_tr, sel_ctrl, sel_baud, enable;
  logic [31:0] data_out;
  logic [31:0] data_in = 32'h0;
  logic        tx_en = 1'b0;

  typedef struct packed {
    int         cyc;
    logic       err;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_pass = 0, n_tot = 0;

  uart_b_host #(.FRAME_BITS(10), .TX_GUARD_BITS(12)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .cmd_ready(cmd_ready), .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_data(rsp_data),
    .sel_tr(sel_tr), .sel_ctrl(sel_ctrl), .sel_baud(sel_baud), .enable(enable),
    .data_out(data_out), .data_in(data_in), .tx_en(tx_en)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cyc %0d)", name, got, exp, cyc);
  endfunction

  // Monitor: every response must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rsp_cycle", cyc, e.cyc);
        chk("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
        chk("rsp_data", {24'b0, rsp_data}, {24'b0, e.data});
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic push(input int c, input logic err, input logic [7:0] d);
    exp_t e;
    e.cyc = c; e.err = err; e.data = d;
    exp_q.push_back(e);
  endtask

  // Returns with the bench sitting in cycle 1 after the acceptance edge.
  task automatic accept(input logic [1:0] op, input logic [19:0] d, output int a);
    int k = 0;
    @(negedge clk);
    while (cmd_ready !== 1'b1 && k < 200) begin @(negedge clk); k++; end
    if (k >= 200) chk("cmd_ready_timeout", 32'd0, 32'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    a = cyc;
  endtask

  task automatic sels_idle(input string name);
    chk(name, {sel_tr, sel_ctrl, sel_baud, enable, (data_out != 0)}, 5'b0);
  endtask

  initial begin
    int a, hi;
    repeat (3) step();
    rst = 1'b0;
    step();
    // Reset state
    chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    chk("rst_rsp", {rsp_valid, rsp_err, rsp_data}, 10'h0);
    sels_idle("rst_sels");

    // Set baud 0x10
    accept(2'b00, 20'h00010, a);
    push(a + 1, 1'b0, 8'h00);
    chk("wrbaud_sel", {sel_baud, enable, sel_ctrl, sel_tr, cmd_ready}, 5'b11000);
    chk("wrbaud_data", data_out, 32'h10);
    step(); step();
    chk("wrbaud_ready_c3", {31'b0, cmd_ready}, 32'd1);

    // Baud=4, send 0xA5 with CFG_CTRL; tx_en high in cycles 4..40
    accept(2'b00, 20'd4, a);
    push(a + 1, 1'b0, 8'h00);
    accept(2'b01, 20'h000A5, a);
    push(a + 41, 1'b0, 8'h00);
    for (int n = 1; n <= 41; n++) begin
      tx_en = (n >= 4 && n <= 40);
      if (n == 1) begin
        chk("send_cfg_sel", {sel_ctrl, enable, sel_tr, sel_baud}, 4'b1100);
        chk("send_cfg_data", data_out, 32'd1);
      end
      if (n == 2) begin
        chk("send_load_sel", {sel_tr, enable, sel_ctrl, sel_baud}, 4'b1100);
        chk("send_load_data", data_out, 32'hA5);
      end
      if (n == 3) sels_idle("send_wait_sels");
      step();
    end
    tx_en = 1'b0;

    // Second send skips CFG_CTRL; tx_en high cycles 3..10
    accept(2'b01, 20'h0003C, a);
    push(a + 11, 1'b0, 8'h00);
    for (int n = 1; n <= 11; n++) begin
      tx_en = (n >= 3 && n <= 10);
      if (n == 1) begin
        chk("send2_load_sel", {sel_tr, enable, sel_ctrl}, 3'b110);
        chk("send2_load_data", data_out, 32'h3C);
      end
      step();
    end
    tx_en = 1'b0;

    // Send timeout: 48 TX_WAIT cycles, response in cycle 50
    accept(2'b01, 20'h0005A, a);
    push(a + 49, 1'b1, 8'h00);
    repeat (50) step();

    // Receive with CFG_CTRL, data_in 0x3C
    data_in = 32'h0000003C;
    accept(2'b10, 20'h0, a);
    push(a + 41, 1'b0, 8'h3C);
    hi = 0;
    for (int n = 1; n <= 45; n++) begin
      if (n == 1) begin
        chk("rx_cfg_sel", {sel_ctrl, enable, sel_tr}, 3'b110);
        chk("rx_cfg_data", data_out, 32'd2);
      end
      if (sel_tr === 1'b1) hi++;
      step();
    end
    chk("rx_sel_tr_cycles", hi, 40);

    // Reset clears rsp_data / baud / ctrl; then baud==0 and reserved-op errors
    rst = 1'b1; step(); rst = 1'b0; step();
    chk("rst2_rsp_data", {24'b0, rsp_data}, 32'h0);
    accept(2'b01, 20'h00011, a);
    push(a, 1'b1, 8'h00);
    sels_idle("baud0_sels");
    step(); step();
    accept(2'b11, 20'h0, a);
    push(a, 1'b1, 8'h00);
    sels_idle("op11_sels");
    step(); step();

    // Reset in the middle of RX_HOLD drops the command
    accept(2'b00, 20'd4, a);
    push(a + 1, 1'b0, 8'h00);
    data_in = 32'h0000005A;
    accept(2'b10, 20'h0, a);
    repeat (9) step();
    chk("midrx_sel_tr_before", {31'b0, sel_tr}, 32'd1);
    rst = 1'b1; #1;
    chk("midrx_rst_ready", {31'b0, cmd_ready}, 32'd1);
    chk("midrx_rst_rsp", {rsp_valid, rsp_err, rsp_data}, 10'h0);
    sels_idle("midrx_rst_sels");
    step(); step();
    rst = 1'b0;
    repeat (60) step();

    accept(2'b00, 20'd4, a);
    push(a + 1, 1'b0, 8'h00);
    accept(2'b10, 20'h0, a);
    push(a + 41, 1'b0, 8'h5A);
    chk("rx2_cfg_sel", {sel_ctrl, enable, sel_tr}, 3'b110);
    chk("rx2_cfg_data", data_out, 32'd2);
    for (int k = 0; k < 100 && exp_q.size() != 0; k++) step();
    step();
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/uart_b_host.md
# uart_b_host

Command-driven initiator for the UART datapath `uart_b_dp`; it drives that block's register-select side (`sel_tr`, `sel_ctrl`, `sel_baud`, `enable`, `data_out`) and reads back `data_in` and `tx_en`.

- Accepts one high-level command at a time: set baud, send byte, or receive byte.
- Sequences the control-register, baud-register and transfer-register accesses the datapath requires.
- Returns a single-cycle response per command.
- Sits between a simple command source (CPU stub or test sequencer) and `uart_b_dp`.

## Interface
Parameters
- `FRAME_BITS`, 10: bit periods in one UART frame (start + 8 data + stop); sets the receive hold time.
- `TX_GUARD_BITS`, 12: bit periods allowed for a transmit before timeout.

Ports
- `clk`  in  1  single clock; everything is rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_op`  in  2  command code: 00 set baud, 01 send byte, 10 receive byte, 11 reserved.
- `cmd_data`  in  20  set baud: divider in clk cycles per bit. Send byte: byte in [7:0].
- `cmd_ready`  out  1  high only in IDLE.
- `rsp_valid`  out  1  one-cycle completion pulse.
- `rsp_err`  out  1  qualifies `rsp_valid`: reserved op, baud==0, or TX timeout.
- `rsp_data`  out  8  received byte; 0 for non-receive ops.
- `sel_tr`  out  1  datapath transfer-register select.
- `sel_ctrl`  out  1  datapath control-register select.
- `sel_baud`  out  1  datapath baud-register select.
- `enable`  out  1  datapath access enable.
- `data_out`  out  32  write data to datapath.
- `data_in`  in  32  datapath receive data; [7:0] is used.
- `tx_en`  in  1  datapath transmitter busy.

## Operation
- FSM states: IDLE, WR_BAUD, CFG_CTRL, TX_LOAD, TX_WAIT, RX_HOLD, RESP.
- Internal registers:
  - `baud_reg[19:0]`, reset 0.
  - `ctrl_shadow[6:0]`, reset 0; mirrors the datapath `tr_ctrl`.
  - `cnt[23:0]` wait counter.
  - `seen_busy` flag.
- IDLE: `cmd_ready`=1. A command is accepted on `cmd_valid`. `cmd_op` and `cmd_data` are captured at acceptance.
- Reserved op, or op 01/10 with `baud_reg`==0: go directly to RESP with `rsp_err`=1.
- Op 00 → WR_BAUD:
  - `enable`=1, `sel_baud`=1, `data_out`={12'b0, `cmd_data`}.
  - `baud_reg` ← `cmd_data`.
  - Next state RESP.
- Op 01:
  - If `ctrl_shadow`≠1, go to CFG_CTRL with `enable`=1, `sel_ctrl`=1, `data_out`=1; `ctrl_shadow` ← 1.
  - Then TX_LOAD: `enable`=1, `sel_tr`=1, `data_out`={24'b0, byte}, for one cycle.
  - Then TX_WAIT: `cnt` counts up from 0. `seen_busy` is set on `tx_en`=1.
  - Success when `seen_busy`=1 and `tx_en`=0.
  - Timeout when `cnt`==`TX_GUARD_BITS`×`baud_reg`−1 → `rsp_err`=1.
  - Both exits go to RESP.
- Op 10:
  - If `ctrl_shadow`≠2, go to CFG_CTRL with `data_out`=2; `ctrl_shadow` ← 2.
  - Then RX_HOLD: `enable`=1 and `sel_tr`=1 held continuously.
  - RX_HOLD lasts `FRAME_BITS`×`baud_reg` cycles, until `cnt` reaches that value −1.
  - On exit, `rsp_data` ← `data_in[7:0]`; go to RESP.
- RESP: `rsp_valid`=1 for one cycle, then IDLE.
- All select/enable outputs are 0 in IDLE, TX_WAIT and RESP, and `data_out`=0 there. At most one select is high in any cycle.
- Arithmetic: products are computed as 24-bit unsigned. Max 12×(2^20−1) < 2^24, so no overflow. `cnt` clears on every state entry.
- `rsp_data` and `rsp_err` hold their values until the next RESP.
- `cmd_valid` while not in IDLE is ignored; no queueing.

## Timing
- Reset values (`rst`=1, any time, including mid-command):
  - State IDLE, `cmd_ready`=1.
  - `rsp_valid`=0, `rsp_err`=0, `rsp_data`=0.
  - All selects and `enable`=0, `data_out`=0.
  - `baud_reg`=0, `ctrl_shadow`=0, `cnt`=0, `seen_busy`=0.
  - An in-flight command is dropped with no response.
- All outputs are registered (state-decoded from registers). Acceptance edge = cycle 0.
- Set baud: WR_BAUD in cycle 1, `rsp_valid` in cycle 2, `cmd_ready` in cycle 3.
- Send, control already 1: TX_LOAD in cycle 1, TX_WAIT from cycle 2. `rsp_valid` comes 1 cycle after the exit condition.
- Send, control change needed: CFG_CTRL in cycle 1, TX_LOAD in cycle 2.
- Receive, control change needed: CFG_CTRL in cycle 1. RX_HOLD covers cycles 2 through 1+10×baud. `rsp_valid` in cycle 2+10×baud.
- Back-to-back commands: a new command can be accepted in the cycle `cmd_ready` returns, i.e. the cycle after `rsp_valid`.

## Test plan
- Reset, then `cmd_op`=00, `cmd_data`=0x00010:
  - Cycle 1: `sel_baud`=1, `enable`=1, `data_out`=0x10.
  - Cycle 2: `rsp_valid`=1, `rsp_err`=0.
- Baud=4, send 0xA5, model `tx_en` high cycles 4–40:
  - Cycle 1: CFG_CTRL with `data_out`=1.
  - Cycle 2: TX_LOAD with `data_out`=0xA5.
  - `rsp_valid` one cycle after `tx_en` falls, `rsp_err`=0.
  - A second send skips CFG_CTRL.
- Baud=4, send with `tx_en` held 0: `rsp_err`=1 after 48 TX_WAIT cycles.
- Baud=4, receive, `data_in`=0x0000003C:
  - Cycle 1: CFG_CTRL with `data_out`=2.
  - `sel_tr` high exactly 40 cycles.
  - `rsp_data`=0x3C, `rsp_valid` in cycle 42.
- After reset, send with `baud_reg`=0: `rsp_valid`+`rsp_err` in cycle 1, no select asserted. Op 11 gives the same response.
- Assert `rst` in the middle of RX_HOLD:
  - All outputs go to reset values immediately.
  - No `rsp_valid`.
  - The next receive re-issues CFG_CTRL.
